// File: rtl/prim_alert_ping_sched_if.sv
// Bundles the scheduler's configuration, receiver handshake and status signals.
// The scheduler uses the master modport; the alert handler side uses the slave modport.
interface prim_alert_ping_sched_if #(
    parameter int NumAlerts = 4,
    parameter int TimerW    = 16,
    parameter int IdxW      = (NumAlerts > 1) ? $clog2(NumAlerts) : 1
);
    logic                 en;
    logic [NumAlerts-1:0] alert_en;
    logic [TimerW-1:0]    wait_cyc;
    logic [TimerW-1:0]    timeout_cyc;
    logic [NumAlerts-1:0] ping_ok;
    logic [NumAlerts-1:0] ping_en;
    logic                 ping_fail;
    logic [IdxW-1:0]      ping_fail_idx;
    logic                 busy;

    modport master (
        input  en, alert_en, wait_cyc, timeout_cyc, ping_ok,
        output ping_en, ping_fail, ping_fail_idx, busy
    );

    modport slave (
        output en, alert_en, wait_cyc, timeout_cyc, ping_ok,
        input  ping_en, ping_fail, ping_fail_idx, busy
    );
endinterface

// File: rtl/prim_alert_ping_sched.sv
// Round-robin liveness pinger for a bank of alert receivers: raises one ping_en
// at a time, waits for the matching ping_ok, and pulses ping_fail on timeout.
module prim_alert_ping_sched #(
    parameter int NumAlerts = 4,
    parameter int TimerW    = 16
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    prim_alert_ping_sched_if.master bus
);
    localparam int IdxW = (NumAlerts > 1) ? $clog2(NumAlerts) : 1;
    localparam logic [IdxW-1:0] LastIdxRst = IdxW'(NumAlerts - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StPing = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [TimerW-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [IdxW-1:0]      last_idx_q, last_idx_d;
    logic [IdxW-1:0]      fail_idx_q, fail_idx_d;
    logic [NumAlerts-1:0] ping_en_q, ping_en_d;
    logic                 fail_q, fail_d;
    logic                 busy_q;

    logic                 sel_found;
    logic [IdxW-1:0]      sel_idx;
    logic [IdxW-1:0]      cand_idx;
    logic [NumAlerts-1:0] sel_onehot;
    int                   cand;

    // Next enabled channel strictly after last_idx, wrapping; scanning offsets
    // downward lets the nearest candidate overwrite farther ones.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = NumAlerts; off >= 1; off--) begin
            cand     = (int'(last_idx_q) + off) % NumAlerts;
            cand_idx = IdxW'(cand);
            if (bus.alert_en[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NumAlerts; i++) begin
            sel_onehot[i] = (sel_idx == IdxW'(i));
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        fail_idx_d = fail_idx_q;
        ping_en_d  = ping_en_q;
        fail_d     = 1'b0;

        if (!bus.en) begin
            state_d   = StIdle;
            cnt_d     = '0;
            ping_en_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|bus.alert_en) begin
                        state_d = StWait;
                        cnt_d   = bus.wait_cyc;
                    end
                end
                StWait: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - TimerW'(1);
                    end else if (sel_found) begin
                        state_d    = StPing;
                        idx_d      = sel_idx;
                        last_idx_d = sel_idx;
                        ping_en_d  = sel_onehot;
                        cnt_d      = bus.timeout_cyc;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StPing: begin
                    // A response on the final cycle still counts as success.
                    if (bus.ping_ok[idx_q]) begin
                        state_d   = StWait;
                        ping_en_d = '0;
                        cnt_d     = bus.wait_cyc;
                    end else if (!bus.alert_en[idx_q]) begin
                        state_d   = StWait;
                        ping_en_d = '0;
                        cnt_d     = bus.wait_cyc;
                    end else if (cnt_q == '0) begin
                        state_d    = StWait;
                        ping_en_d  = '0;
                        cnt_d      = bus.wait_cyc;
                        fail_d     = 1'b1;
                        fail_idx_d = idx_q;
                    end else begin
                        cnt_d = cnt_q - TimerW'(1);
                    end
                end
                default: begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    ping_en_d = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            last_idx_q <= LastIdxRst;
            fail_idx_q <= '0;
            ping_en_q  <= '0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            fail_idx_q <= fail_idx_d;
            ping_en_q  <= ping_en_d;
            fail_q     <= fail_d;
            busy_q     <= (state_d != StIdle);
        end
    end

    assign bus.ping_en       = ping_en_q;
    assign bus.ping_fail     = fail_q;
    assign bus.ping_fail_idx = fail_idx_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_prim_alert_ping_sched.sv
// Directed bench for prim_alert_ping_sched: a per-cycle vector table plus
// hand-written sequences for round-robin, ok-at-deadline, ignore, abort and reset cases.
module tb_prim_alert_ping_sched;
    localparam int NumAlerts = 4;
    localparam int TimerW    = 16;

    logic clk_i;
    logic rst_ni;

    prim_alert_ping_sched_if #(.NumAlerts(NumAlerts), .TimerW(TimerW)) bus ();

    prim_alert_ping_sched #(.NumAlerts(NumAlerts), .TimerW(TimerW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic        en;
        logic [3:0]  alert_en;
        logic [15:0] wait_cyc;
        logic [15:0] timeout_cyc;
        logic [3:0]  ping_ok;
        logic [3:0]  exp_ping_en;
        logic        exp_fail;
        logic [1:0]  exp_fail_idx;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [12];

    int n_cmp;
    int n_bad;
    int fail_seen;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        if (bus.ping_fail) fail_seen++;
    endtask

    task automatic drive(input logic en, input logic [3:0] alert_en, input logic [15:0] wt,
                         input logic [15:0] to, input logic [3:0] ok);
        bus.en          = en;
        bus.alert_en    = alert_en;
        bus.wait_cyc    = wt;
        bus.timeout_cyc = to;
        bus.ping_ok     = ok;
    endtask

    task automatic reset_dut();
        drive(1'b0, 4'b0000, 16'd0, 16'd0, 4'b0000);
        rst_ni = 1'b0;
        #12;
        @(posedge clk_i);
        #1;
        rst_ni    = 1'b1;
        fail_seen = 0;
    endtask

    // Steps until some ping_en bit rises; returns the number of edges taken.
    task automatic wait_ping(input int budget, output int cycles);
        cycles = 0;
        while (bus.ping_en == '0 && cycles < budget) begin
            step();
            cycles++;
        end
        if (bus.ping_en == '0) check("ping_wait_bound", 32'(cycles), 32'(budget + 1));
    endtask

    initial begin
        int cyc;
        int n;
        logic [3:0] order [5];
        n_cmp     = 0;
        n_bad     = 0;
        fail_seen = 0;
        rst_ni    = 1'b0;

        // alert_en=0101, silent receivers, wait=0, timeout=3
        vecs[0]  = '{1'b1, 4'b0101, 16'd0, 16'd3, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
        vecs[1]  = '{1'b1, 4'b0101, 16'd0, 16'd3, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1};
        vecs[2]  = '{1'b1, 4'b0101, 16'd0, 16'd3, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1};
        vecs[3]  = '{1'b1, 4'b0101, 16'd0, 16'd3, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1};
        vecs[4]  = '{1'b1, 4'b0101, 16'd0, 16'd3, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1};
        vecs[5]  = '{1'b1, 4'b0101, 16'd0, 16'd3, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1};
        vecs[6]  = '{1'b1, 4'b0101, 16'd0, 16'd3, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b1};
        vecs[7]  = '{1'b1, 4'b0101, 16'd0, 16'd3, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b1};
        vecs[8]  = '{1'b1, 4'b0101, 16'd0, 16'd3, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b1};
        vecs[9]  = '{1'b1, 4'b0101, 16'd0, 16'd3, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b1};
        vecs[10] = '{1'b1, 4'b0101, 16'd0, 16'd3, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b1};
        vecs[11] = '{1'b1, 4'b0101, 16'd0, 16'd3, 4'b0000, 4'b0001, 1'b0, 2'd2, 1'b1};

        // Reset values
        reset_dut();
        check("rst_ping_en", 32'(bus.ping_en), 32'h0);
        check("rst_fail", 32'(bus.ping_fail), 32'h0);
        check("rst_fail_idx", 32'(bus.ping_fail_idx), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);

        // Table: alternate 0001/0100 with timeouts on idx 0 then 2
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].en, vecs[i].alert_en, vecs[i].wait_cyc, vecs[i].timeout_cyc, vecs[i].ping_ok);
            step();
            check($sformatf("vec%0d_ping_en", i), 32'(bus.ping_en), 32'(vecs[i].exp_ping_en));
            check($sformatf("vec%0d_fail", i), 32'(bus.ping_fail), 32'(vecs[i].exp_fail));
            check($sformatf("vec%0d_fail_idx", i), 32'(bus.ping_fail_idx), 32'(vecs[i].exp_fail_idx));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
        end

        // Round robin over all four, ok returned two cycles after ping_en
        reset_dut();
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        drive(1'b1, 4'b1111, 16'd2, 16'd5, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            wait_ping(20, cyc);
            check($sformatf("rr%0d_ping_en", k), 32'(bus.ping_en), 32'(order[k]));
            if (k > 0) check($sformatf("rr%0d_gap", k), 32'(cyc), 32'd3);
            step();
            bus.ping_ok = order[k];
            step();
            bus.ping_ok = 4'b0000;
            check($sformatf("rr%0d_ok_clears", k), 32'(bus.ping_en), 32'h0);
        end
        check("rr_no_fail", 32'(fail_seen), 32'd0);

        // ok exactly on the cnt==0 cycle wins over timeout
        reset_dut();
        drive(1'b1, 4'b0011, 16'd1, 16'd3, 4'b0000);
        wait_ping(20, cyc);
        check("okdl_ping_en", 32'(bus.ping_en), 32'h1);
        step(); step(); step();
        check("okdl_still_high", 32'(bus.ping_en), 32'h1);
        bus.ping_ok = 4'b0001;
        step();
        bus.ping_ok = 4'b0000;
        check("okdl_cleared", 32'(bus.ping_en), 32'h0);
        check("okdl_no_fail", 32'(bus.ping_fail), 32'h0);
        wait_ping(20, cyc);
        check("okdl_gap", 32'(cyc), 32'd2);
        check("okdl_next", 32'(bus.ping_en), 32'h2);
        check("okdl_fail_cnt", 32'(fail_seen), 32'd0);

        // ping_ok on a foreign channel is ignored; fail on idx 1
        reset_dut();
        drive(1'b1, 4'b0010, 16'd0, 16'd4, 4'b1000);
        wait_ping(20, cyc);
        check("ign_ping_en", 32'(bus.ping_en), 32'h2);
        n = 0;
        while (!bus.ping_fail && n < 20) begin
            step();
            n++;
        end
        check("ign_fail_after", 32'(n), 32'd5);
        check("ign_fail_idx", 32'(bus.ping_fail_idx), 32'd1);
        check("ign_ping_cleared", 32'(bus.ping_en), 32'h0);
        bus.ping_ok = 4'b0000;
        step();
        check("ign_fail_one_cycle", 32'(bus.ping_fail), 32'h0);
        check("ign_fail_idx_held", 32'(bus.ping_fail_idx), 32'd1);

        // Dropping en_i mid-ping, then resuming at the next channel
        reset_dut();
        drive(1'b1, 4'b1111, 16'd0, 16'd6, 4'b0000);
        wait_ping(20, cyc);
        check("en_ping0", 32'(bus.ping_en), 32'h1);
        step();
        bus.en = 1'b0;
        step();
        check("en_off_ping_en", 32'(bus.ping_en), 32'h0);
        check("en_off_busy", 32'(bus.busy), 32'h0);
        check("en_off_fail", 32'(bus.ping_fail), 32'h0);
        step();
        check("en_off_idle", 32'(bus.busy), 32'h0);
        bus.en = 1'b1;
        wait_ping(20, cyc);
        check("en_resume_gap", 32'(cyc), 32'd2);
        check("en_resume_next", 32'(bus.ping_en), 32'h2);
        check("en_no_fail", 32'(fail_seen), 32'd0);

        // alert_en cleared while pinging idx 2, then async reset mid-ping
        reset_dut();
        drive(1'b1, 4'b0100, 16'd1, 16'd6, 4'b0000);
        wait_ping(20, cyc);
        check("abort_ping2", 32'(bus.ping_en), 32'h4);
        bus.alert_en = 4'b0000;
        step();
        check("abort_ping_en", 32'(bus.ping_en), 32'h0);
        check("abort_busy_wait", 32'(bus.busy), 32'h1);
        check("abort_no_fail", 32'(bus.ping_fail), 32'h0);
        step();
        check("abort_wait2", 32'(bus.busy), 32'h1);
        step();
        check("abort_idle", 32'(bus.busy), 32'h0);
        check("abort_fail_cnt", 32'(fail_seen), 32'd0);
        bus.alert_en = 4'b0100;
        wait_ping(20, cyc);
        check("arst_ping2", 32'(bus.ping_en), 32'h4);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_ping_en", 32'(bus.ping_en), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_fail", 32'(bus.ping_fail), 32'h0);
        check("arst_fail_idx", 32'(bus.ping_fail_idx), 32'h0);
        #10;
        rst_ni = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
